// File: rtl/acc_req_queue.sv
// Per-accumulator request queues between commit and the FP accumulator arbiter.
// One independent FIFO per accumulator register; heads are presented in parallel.
module acc_req_queue #(
    parameter int N_ACC = 3,
    parameter int DEPTH = 4,
    localparam int AW = (N_ACC > 1) ? $clog2(N_ACC) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_valid,
    input  logic [AW-1:0]         enq_acc,
    input  logic [31:0]           enq_data,
    output logic                  enq_ready,
    output logic [N_ACC-1:0]      acc_req_valid,
    output logic [N_ACC*32-1:0]   acc_data,
    input  logic [N_ACC-1:0]      acc_req_ready,
    output logic                  empty,
    output logic [N_ACC*CW-1:0]   count
);

    logic [31:0]    mem    [N_ACC][DEPTH];
    logic [PW-1:0]  rd_ptr [N_ACC];
    logic [PW-1:0]  wr_ptr [N_ACC];
    logic [CW-1:0]  cnt    [N_ACC];

    logic           acc_ok;
    logic [CW-1:0]  sel_cnt;
    logic [N_ACC-1:0] enq_hit;
    logic [N_ACC-1:0] deq_hit;

    // Look up the occupancy of the targeted queue; out-of-range indices never accept.
    always_comb begin
        acc_ok  = 1'b0;
        sel_cnt = '0;
        for (int i = 0; i < N_ACC; i++) begin
            if (enq_acc == AW'(i)) begin
                acc_ok  = 1'b1;
                sel_cnt = cnt[i];
            end
        end
        enq_ready = acc_ok && (sel_cnt != CW'(DEPTH));
    end

    // Per-queue enqueue/dequeue strobes and the registered-only output view.
    always_comb begin
        enq_hit       = '0;
        deq_hit       = '0;
        acc_req_valid = '0;
        acc_data      = '0;
        count         = '0;
        empty         = 1'b1;
        for (int i = 0; i < N_ACC; i++) begin
            enq_hit[i]           = enq_valid && enq_ready && (enq_acc == AW'(i));
            acc_req_valid[i]     = (cnt[i] != '0);
            deq_hit[i]           = acc_req_valid[i] && acc_req_ready[i];
            acc_data[i*32 +: 32] = mem[i][rd_ptr[i]];
            count[i*CW +: CW]    = cnt[i];
            if (cnt[i] != '0) begin
                empty = 1'b0;
            end
        end
    end

    // Pointer and occupancy update; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ACC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_ACC; i++) begin
                if (enq_hit[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (deq_hit[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (enq_hit[i] && !deq_hit[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!enq_hit[i] && deq_hit[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Entry storage; contents are not reset and only matter while valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ACC; i++) begin
            if (enq_hit[i] && !reset) begin
                mem[i][wr_ptr[i]] <= enq_data;
            end
        end
    end

endmodule

// File: doc/acc_req_queue.md
ACC_REQ_QUEUE -- requirements
Module: acc_req_queue

Interface
REQ-001 Parameter N_ACC, 3, number of FP accumulator registers targeted by this core.
REQ-002 Parameter DEPTH, 4, entries per accumulator queue; power of two, at least 2.
REQ-003 clk input 1 clock; all state updates on posedge clk.
REQ-004 reset input 1 synchronous, active-high reset.
REQ-005 enq_valid input 1 commit stage presents an accumulate request this cycle.
REQ-006 enq_acc input $clog2(N_ACC) target accumulator index of the request.
REQ-007 enq_data input 32 single-precision addend.
REQ-008 enq_ready output 1 queue for enq_acc can accept the request this cycle.
REQ-009 acc_req_valid output 1 per accumulator [N_ACC] head entry valid toward the accumulator arbiter.
REQ-010 acc_data output 32 per accumulator [N_ACC] head-entry addend.
REQ-011 acc_req_ready input 1 per accumulator [N_ACC] arbiter accepts the head entry this cycle.
REQ-012 empty output 1 all N_ACC queues hold zero entries.
REQ-013 count output $clog2(DEPTH+1) per accumulator [N_ACC] current occupancy of each queue.

Function
REQ-014 The block SHALL hold N_ACC independent FIFOs, each with a DEPTH x 32 storage array, a read pointer, a write pointer and an occupancy counter.
REQ-015 Enqueue fires when enq_valid && enq_ready; the data is written to queue enq_acc at its write pointer, and the write pointer and count advance at the next edge.
REQ-016 enq_ready SHALL be combinational, equal to count[enq_acc] != DEPTH, and independent of acc_req_ready; a full queue never accepts, even when it dequeues in the same cycle.
REQ-017 enq_valid with enq_ready low SHALL leave all state unchanged; the producer holds the request.
REQ-018 enq_acc >= N_ACC SHALL force enq_ready low and SHALL not modify any queue.
REQ-019 acc_req_valid[i] SHALL equal count[i] != 0; acc_data[i] SHALL be the entry at read pointer i, and SHALL be driven from storage or registers with no combinational path from enq_data.
REQ-020 Dequeue of queue i fires when acc_req_valid[i] && acc_req_ready[i]; read pointer i advances and count[i] decrements at the next edge.
REQ-021 An enqueue into an empty queue SHALL be visible on acc_req_valid one cycle later, with no fall-through bypass.
REQ-022 Simultaneous enqueue and dequeue on the same non-full, non-empty queue SHALL keep count unchanged and advance both pointers.
REQ-023 The pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL never exceed DEPTH and SHALL never go below 0.
REQ-025 Each queue SHALL present its entries in enqueue order; there is no ordering between different queues.
REQ-026 acc_req_valid[i] and acc_data[i] SHALL stay stable while acc_req_valid[i] is high and acc_req_ready[i] is low.
REQ-027 empty SHALL be combinational from the counts, equal to the AND over i of count[i] == 0; it is used by the fork/join logic to detect a drained core.
REQ-028 Dequeues on different queues in the same cycle SHALL be independent.

Reset
REQ-029 On reset, all pointers and counts SHALL go to 0, acc_req_valid SHALL be 0 for all queues, and empty SHALL be 1.
REQ-030 Reset SHALL take priority over a simultaneous enqueue or dequeue; entries in flight are discarded.
REQ-031 Storage contents need no reset; acc_data is don't-care while acc_req_valid is low.

Verification
REQ-032 Scenario: reset, then enqueue acc=1 data=0x3F800000 with acc_req_ready[1]=0. Required: acc_req_valid[1]=1 next cycle, acc_data[1]=0x3F800000, count[1]=1, empty=0.
REQ-033 Scenario: fill queue 0 with 4 entries (0x1..0x4) while ready is low, then present a 5th with ready low. Required: enq_ready=0 and count[0]=4. Then raise acc_req_ready[0] for 4 cycles. Required: outputs 0x1,0x2,0x3,0x4 in order, then valid=0.
REQ-034 Scenario: queue 2 holds 2 entries; enqueue and dequeue on queue 2 for 6 cycles. Required: count[2] stays 2, data stays in order across pointer wrap.
REQ-035 Scenario: queue 0 full and acc_req_ready[0]=1 in the same cycle as enq_valid for acc 0. Required: enq_ready=0, and count[0]=3 next cycle.
REQ-036 Scenario: reset asserted while queues 0 and 1 are non-empty and an enqueue fires. Required: next cycle all counts are 0, all valids are 0, and empty=1.
REQ-037 Scenario: enq_acc=3 with N_ACC=3. Required: enq_ready=0 and no count changes.
